imem_cache_ctrl: RTL and testbench

Parametrised instruction-side memory controller. It puts a direct-mapped, read-only instruction cache between the fetch stage and the backing instruction memory.
- Hits return in the same cycle with no stall.
- On a miss, memReady is dropped and the controller runs a multi-beat line refill over a req/ack + rvalid handshake.
- A flush input invalidates the whole cache to support fence.i.
- Saturating hit/miss counters are exposed for performance monitoring.

---
 rtl/imem_cache_ctrl_pkg.sv | 41 ++++
 rtl/imem_cache_ctrl_if.sv | 38 +++
 rtl/imem_cache_ctrl_array.sv | 75 +++++++
 rtl/imem_cache_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_imem_cache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_cache_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_cache_pkg
// Shared definitions for the instruction-side cache controller:
//   - refill FSM state encoding
//   - address-field width derivation (offset / index / tag)
//   - line-alignment helper for the refill byte address
// No ports; imported by the controller, its storage array and the interface
// users.
// ----------------------------------------------------------------------------
package imem_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fsm_state_e;

  // Word-offset field width inside a line.
  function automatic int off_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Line-index field width.
  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above index, offset and the 2 byte-select bits.
  function automatic int tag_width(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 32'sd2 - $clog2(words_per_line) - $clog2(lines);
  endfunction

  // Clears the byte-select and word-offset bits so the result points at the
  // first byte of the line. Operates on a 64-bit container; callers slice.
  function automatic logic [63:0] line_align(input logic [63:0] byte_addr, input int off_w);
    logic [63:0] mask;
    mask = (64'd1 << (off_w + 32'sd2)) - 64'd1;
    return byte_addr & ~mask;
  endfunction

endpackage

// File: rtl/imem_cache_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_cache_ctrl_if
// Bundles the fetch-side and refill-side signals of the instruction cache
// controller.
//   Fetch side : ren, address, flush (core -> cache); dataout, memReady back
//   Refill side: mem_req, mem_addr (cache -> memory); mem_ack, mem_rvalid,
//                mem_rdata back
// Modports:
//   slave  - the cache controller's view
//   master - the environment's view (core plus backing memory)
// ----------------------------------------------------------------------------
interface imem_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ren;
  logic [ADDR_W-1:0] address;
  logic              flush;
  logic [DATA_W-1:0] dataout;
  logic              memReady;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ren, address, flush, mem_ack, mem_rvalid, mem_rdata,
    output dataout, memReady, mem_req, mem_addr
  );

  modport master (
    output ren, address, flush, mem_ack, mem_rvalid, mem_rdata,
    input  dataout, memReady, mem_req, mem_addr
  );

endinterface

// File: rtl/imem_cache_ctrl_array.sv
// ----------------------------------------------------------------------------
// icache_array
// Direct-mapped storage: per-line valid bit, tag and WORDS_PER_LINE data
// words. Only the valid bits are reset; tag and data contents are
// meaningless until the line's valid bit is set.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 clear every valid bit at the next edge
//   rd_idx, rd_off        combinational read address
//   rd_valid/rd_tag/rd_data  combinational read data
//   wr_en, wr_idx, wr_off, wr_data  single-port data write
//   wr_tag_en, wr_tag     tag write for line wr_idx
//   set_valid             mark line wr_idx valid (flush takes precedence)
// ----------------------------------------------------------------------------
module icache_array
  import imem_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_W         = 32,
  parameter int TAG_W          = 24,
  localparam int IDX_W         = idx_width(LINES),
  localparam int OFF_W         = off_width(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_tag_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              set_valid
);

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES*WORDS_PER_LINE];

  // Valid bits: async reset, flush-all wins over a same-cycle line fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (flush) begin
      valid_r <= {LINES{1'b0}};
    end else if (set_valid) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag store, written once per refill on the last beat.
  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  // Data store, one word per refill beat, addressed as {line, word}.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[{wr_idx, wr_off}] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[{rd_idx, rd_off}];

endmodule

// File: rtl/imem_cache_ctrl.sv
// ----------------------------------------------------------------------------
// imem_cache_ctrl
// Direct-mapped, read-only instruction cache between the fetch stage and the
// backing instruction memory. Hits return combinationally with no stall; a
// miss drops memReady and refills the whole line over a req/ack handshake
// followed by WORDS_PER_LINE mem_rvalid beats (gaps allowed).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   bus (slave)       ren/address/flush in, dataout/memReady out,
//                     mem_req/mem_addr out, mem_ack/mem_rvalid/mem_rdata in
//   hit_count         saturating count of hit fetches
//   miss_count        saturating count of misses (one per miss, not per stall)
// ----------------------------------------------------------------------------
module imem_cache_ctrl
  import imem_cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  imem_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OFF_W    = off_width(WORDS_PER_LINE);
  localparam int IDX_W    = idx_width(LINES);
  localparam int TAG_W    = tag_width(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int LINE_LSB = OFF_W + 2;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [OFF_W-1:0] BEAT_ONE  = {{(OFF_W-1){1'b0}}, 1'b1};

  fsm_state_e        state_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [OFF_W-1:0]  beat_r;
  logic              poison_r;
  logic [CNT_W-1:0]  hit_count_r;
  logic [CNT_W-1:0]  miss_count_r;
  logic [DATA_W-1:0] dataout_r;

  logic [OFF_W-1:0]  req_off_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  fill_idx_s;
  logic [TAG_W-1:0]  fill_tag_s;
  logic [63:0]       line_wide_s;
  logic [ADDR_W-1:0] line_addr_s;

  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [DATA_W-1:0] rd_data_s;

  logic              hit_s;
  logic              lookup_s;
  logic              hit_fire_s;
  logic              miss_fire_s;
  logic              wr_en_s;
  logic              wr_last_s;
  logic              set_valid_s;
  logic [DATA_W-1:0] dataout_s;
  logic              memready_s;
  logic              unused_s;

  // Lookup fields come from the live fetch address; the refill fields come
  // only from the latched line address, so the core's address is not needed
  // once the miss has been taken.
  assign req_off_s   = bus.address[OFF_W+1:2];
  assign req_idx_s   = bus.address[LINE_LSB +: IDX_W];
  assign req_tag_s   = bus.address[ADDR_W-1 -: TAG_W];
  assign fill_idx_s  = mem_addr_r[LINE_LSB +: IDX_W];
  assign fill_tag_s  = mem_addr_r[ADDR_W-1 -: TAG_W];
  assign line_wide_s = line_align(64'(bus.address), OFF_W);
  assign line_addr_s = line_wide_s[ADDR_W-1:0];
  assign unused_s    = ^{bus.address[1:0], line_wide_s[63:ADDR_W]};

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_W         (DATA_W),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .rd_idx    (req_idx_s),
    .rd_off    (req_off_s),
    .rd_valid  (rd_valid_s),
    .rd_tag    (rd_tag_s),
    .rd_data   (rd_data_s),
    .wr_en     (wr_en_s),
    .wr_idx    (fill_idx_s),
    .wr_off    (beat_r),
    .wr_data   (bus.mem_rdata),
    .wr_tag_en (wr_last_s),
    .wr_tag    (fill_tag_s),
    .set_valid (set_valid_s)
  );

  // Tag compare against pre-flush valid bits of the addressed line.
  always_comb begin
    hit_s = 1'b0;
    if (bus.ren && rd_valid_s && (rd_tag_s == req_tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  assign lookup_s    = (state_r == ST_IDLE);
  assign hit_fire_s  = lookup_s & hit_s;
  assign miss_fire_s = lookup_s & bus.ren & ~hit_s;

  // Refill writes: a beat only counts in FILL, so stray beats elsewhere are
  // dropped. A flush seen during the refill (or on its last beat) keeps the
  // line invalid.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_last_s   = 1'b0;
    set_valid_s = 1'b0;
    if ((state_r == ST_FILL) && bus.mem_rvalid) begin
      wr_en_s     = 1'b1;
      wr_last_s   = (beat_r == LAST_BEAT);
      set_valid_s = (beat_r == LAST_BEAT) && !poison_r && !bus.flush;
    end else begin
      wr_en_s     = 1'b0;
      wr_last_s   = 1'b0;
      set_valid_s = 1'b0;
    end
  end

  // Fetch-side outputs: hit data is combinational, otherwise the last
  // delivered word is held. memReady is forced high while in reset.
  always_comb begin
    dataout_s  = dataout_r;
    memready_s = 1'b1;
    if (hit_fire_s) begin
      dataout_s = rd_data_s;
    end else begin
      dataout_s = dataout_r;
    end
    if (reset) begin
      memready_s = 1'b1;
    end else if (hit_fire_s || (lookup_s && !bus.ren)) begin
      memready_s = 1'b1;
    end else begin
      memready_s = 1'b0;
    end
  end

  // Refill FSM, handshake registers and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      beat_r       <= {OFF_W{1'b0}};
      poison_r     <= 1'b0;
      hit_count_r  <= {CNT_W{1'b0}};
      miss_count_r <= {CNT_W{1'b0}};
      dataout_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_fire_s) begin
            state_r    <= ST_REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= line_addr_s;
            beat_r     <= {OFF_W{1'b0}};
            // A flush in the miss cycle clears the array but must also
            // prevent the line now being fetched from becoming valid.
            poison_r   <= bus.flush;
            if (miss_count_r != CNT_MAX) begin
              miss_count_r <= miss_count_r + CNT_ONE;
            end
          end else if (hit_fire_s) begin
            dataout_r <= rd_data_s;
            if (hit_count_r != CNT_MAX) begin
              hit_count_r <= hit_count_r + CNT_ONE;
            end
          end
        end
        ST_REQ: begin
          if (bus.flush) begin
            poison_r <= 1'b1;
          end
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.flush) begin
            poison_r <= 1'b1;
          end
          if (bus.mem_rvalid) begin
            if (beat_r == LAST_BEAT) begin
              beat_r  <= {OFF_W{1'b0}};
              state_r <= ST_IDLE;
            end else begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          beat_r    <= {OFF_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.dataout  = dataout_s;
  assign bus.memReady = memready_s;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = mem_addr_r;
  assign hit_count    = hit_count_r;
  assign miss_count   = miss_count_r;

endmodule

// File: tb/tb_imem_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_cache_ctrl
// Directed bench for imem_cache_ctrl. A second instance with 2-bit counters
// mirrors the same stimulus to exercise counter saturation.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// one unit later.
// ----------------------------------------------------------------------------
module tb_imem_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [1:0]  hit_sat;
  logic [1:0]  miss_sat;
  int          n_cmp = 0;
  int          n_bad = 0;

  imem_cache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  imem_cache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_sat ();

  imem_cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  imem_cache_ctrl #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_sat),
    .hit_count  (hit_sat),
    .miss_count (miss_sat)
  );

  assign bus_sat.ren        = bus.ren;
  assign bus_sat.address    = bus.address;
  assign bus_sat.flush      = bus.flush;
  assign bus_sat.mem_ack    = bus.mem_ack;
  assign bus_sat.mem_rvalid = bus.mem_rvalid;
  assign bus_sat.mem_rdata  = bus.mem_rdata;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serves a refill; entered in the first REQ cycle, returns in the lookup
  // cycle that follows the last beat. Junk rvalid beats are offered while
  // ack is withheld; flush is pulsed together with beat flush_beat.
  task automatic serve(input logic [31:0] exp_addr, input int ack_delay,
                       input logic [31:0] d0, input int gap, input int flush_beat);
    #1;
    chk("req_asserted", bus.mem_req, 64'd1);
    chk("req_addr", bus.mem_addr, exp_addr);
    chk("req_stall", bus.memReady, 64'd0);
    for (int w = 0; w < ack_delay; w++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_0000 + w;
      #1;
      chk("ack_wait_req", bus.mem_req, 64'd1);
      chk("ack_wait_stall", bus.memReady, 64'd0);
      step();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_ack    = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("req_dropped", bus.mem_req, 64'd0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("gap_stall", bus.memReady, 64'd0);
        step();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d0 + b;
      bus.flush      = (b == flush_beat);
      #1;
      chk("fill_stall", bus.memReady, 64'd0);
      step();
      bus.mem_rvalid = 1'b0;
      bus.flush      = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.ren        = 1'b0;
    bus.address    = 32'h0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (2) step();
    #1;
    chk("rst_memready", bus.memReady, 64'd1);
    chk("rst_mem_req", bus.mem_req, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_dataout", bus.dataout, 64'd0);
    chk("rst_hit", hit_count, 64'd0);
    chk("rst_miss", miss_count, 64'd0);
    reset = 1'b0;
    step();

    // Cold miss at 0x100, back-to-back beats A0..A3.
    bus.ren     = 1'b1;
    bus.address = 32'h100;
    #1;
    chk("cold_miss_stall", bus.memReady, 64'd0);
    chk("cold_req_not_yet", bus.mem_req, 64'd0);
    step();
    serve(32'h100, 0, 32'hA0, 0, -1);
    #1;
    chk("cold_ready", bus.memReady, 64'd1);
    chk("cold_data", bus.dataout, 64'hA0);
    chk("cold_miss_cnt", miss_count, 64'd1);
    chk("cold_hit_cnt", hit_count, 64'd0);

    // Sequential hits in the refilled line.
    step();
    bus.address = 32'h104;
    #1;
    chk("seq_104", bus.dataout, 64'hA1);
    chk("seq_104_ready", bus.memReady, 64'd1);
    chk("seq_hit_1", hit_count, 64'd1);
    step();
    bus.address = 32'h108;
    #1;
    chk("seq_108", bus.dataout, 64'hA2);
    chk("seq_108_ready", bus.memReady, 64'd1);
    step();
    bus.address = 32'h10C;
    #1;
    chk("seq_10c", bus.dataout, 64'hA3);
    chk("seq_10c_ready", bus.memReady, 64'd1);
    step();
    bus.ren = 1'b0;
    #1;
    chk("seq_hit_4", hit_count, 64'd4);
    chk("sat_hit", hit_sat, 64'd3);
    chk("idle_ready", bus.memReady, 64'd1);
    step();
    #1;
    chk("idle_hold", bus.dataout, 64'hA3);

    // Conflict on index 0: 0x100 vs 0x1100.
    bus.ren     = 1'b1;
    bus.address = 32'h100;
    #1;
    chk("conf_hit_100", bus.dataout, 64'hA0);
    step();
    bus.address = 32'h1100;
    #1;
    chk("conf_miss_1100", bus.memReady, 64'd0);
    step();
    serve(32'h1100, 0, 32'hB0, 0, -1);
    #1;
    chk("conf_data_1100", bus.dataout, 64'hB0);
    chk("conf_miss_cnt", miss_count, 64'd2);
    step();
    bus.address = 32'h100;
    #1;
    chk("conf_remiss_100", bus.memReady, 64'd0);
    step();
    serve(32'h100, 0, 32'hA0, 0, -1);
    #1;
    chk("conf_refill_100", bus.dataout, 64'hA0);
    chk("conf_miss_cnt3", miss_count, 64'd3);

    // Flush during FILL of 0x200: line stays invalid, fetch re-misses.
    step();
    bus.address = 32'h200;
    #1;
    chk("flush_miss", bus.memReady, 64'd0);
    step();
    serve(32'h200, 0, 32'hC0, 0, 0);
    #1;
    chk("flush_poison_remiss", bus.memReady, 64'd0);
    step();
    serve(32'h200, 0, 32'hD0, 0, -1);
    #1;
    chk("flush_miss_cnt", miss_count, 64'd5);
    chk("sat_miss", miss_sat, 64'd3);
    chk("flush_data", bus.dataout, 64'hD0);

    // Reset after the second beat of a refill of 0x340.
    step();
    bus.address = 32'h340;
    #1;
    chk("rstmid_miss", bus.memReady, 64'd0);
    step();
    #1;
    chk("rstmid_req", bus.mem_req, 64'd1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hE0;
    step();
    bus.mem_rdata = 32'hE1;
    step();
    bus.mem_rvalid = 1'b0;
    reset          = 1'b1;
    #1;
    chk("rstmid_req_drop", bus.mem_req, 64'd0);
    chk("rstmid_ready", bus.memReady, 64'd1);
    chk("rstmid_miss_cnt", miss_count, 64'd0);
    chk("rstmid_hit_cnt", hit_count, 64'd0);
    chk("rstmid_dataout", bus.dataout, 64'd0);
    chk("rstmid_sat_hit", hit_sat, 64'd0);
    step();
    reset          = 1'b0;
    bus.ren        = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD;
    step();
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("stray_idle_ready", bus.memReady, 64'd1);
    bus.ren     = 1'b1;
    bus.address = 32'h340;
    #1;
    chk("post_rst_miss", bus.memReady, 64'd0);
    step();
    serve(32'h340, 0, 32'hE0, 0, -1);
    #1;
    chk("post_rst_data", bus.dataout, 64'hE0);
    step();
    bus.address = 32'h344;
    #1;
    chk("post_rst_344", bus.dataout, 64'hE1);
    chk("post_rst_hit", hit_count, 64'd1);
    chk("post_rst_miss_cnt", miss_count, 64'd1);
    bus.ren        = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD;
    step();
    step();
    bus.mem_rvalid = 1'b0;
    bus.ren        = 1'b1;
    #1;
    chk("stray_kept_344", bus.dataout, 64'hE1);
    chk("stray_kept_ready", bus.memReady, 64'd1);

    // Ack delayed 5 cycles, one beat every 3rd cycle, line 0x480.
    step();
    bus.address = 32'h480;
    #1;
    chk("gap_miss", bus.memReady, 64'd0);
    step();
    serve(32'h480, 5, 32'hF0, 2, -1);
    #1;
    chk("gap_ready", bus.memReady, 64'd1);
    chk("gap_data_480", bus.dataout, 64'hF0);
    step();
    bus.address = 32'h48C;
    #1;
    chk("gap_data_48c", bus.dataout, 64'hF3);
    chk("gap_hit_cnt", hit_count, 64'd3);
    chk("gap_miss_cnt", miss_count, 64'd2);
    chk("gap_sat_miss", miss_sat, 64'd2);

    bus.ren = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
